// File: rtl/sprite_dma.sv
// Sprite attribute DMA: takes the Z80 bus, copies LEN bytes from {src_hi,8'h00}
// into objram at DST_BASE one byte per RD/CAP/WR triple, then hands the bus back.
module sprite_dma #(
  parameter int         LEN      = 384,
  parameter logic [9:0] DST_BASE = 10'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_ena,
  input  logic        start,
  input  logic [7:0]  src_hi,
  output logic        busrq_n,
  input  logic        busak_n,
  output logic        dma_active,
  output logic        busy,
  output logic [15:0] dma_addr,
  output logic        dma_rd_n,
  output logic        dma_wr_n,
  output logic        dma_obj_ena_n,
  input  logic [7:0]  dma_din,
  output logic [7:0]  dma_dout,
  output logic        done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4,
    S_REL  = 3'd5
  } state_t;

  localparam logic [9:0] LAST_IDX = 10'(LEN - 1);

  state_t      state;
  logic [7:0]  src_q;
  logic [9:0]  idx;
  logic [9:0]  idx_nxt;
  logic [9:0]  obj_addr;

  assign idx_nxt   = idx + 10'd1;
  assign obj_addr  = DST_BASE + idx;
  assign dbg_state = state;

  // Bus handshake: busrq_n low asks for the bus; the grant is busak_n low as
  // sampled in REQ. Giving it back is busrq_n high, and the CPU's busak_n high
  // sampled in REL ends the transfer. The grant is assumed stable while active.
  // Outputs are assigned on the transition into the state they belong to, so
  // every strobe is a flop and holds steady for as long as the state is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      src_q         <= 8'h00;
      idx           <= 10'd0;
      busrq_n       <= 1'b1;
      dma_active    <= 1'b0;
      busy          <= 1'b0;
      dma_addr      <= 16'h0000;
      dma_rd_n      <= 1'b1;
      dma_wr_n      <= 1'b1;
      dma_obj_ena_n <= 1'b1;
      dma_dout      <= 8'h00;
      done          <= 1'b0;
    end else if (step_ena) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q   <= src_hi;
            idx     <= 10'd0;
            busrq_n <= 1'b0;
            busy    <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (!busak_n) begin
            dma_active <= 1'b1;
            dma_rd_n   <= 1'b0;
            dma_addr   <= {src_q, 8'h00} + {6'b0, idx};
            state      <= S_RD;
          end
        end
        S_RD: begin
          state <= S_CAP;
        end
        S_CAP: begin
          // Synchronous RAM returns data one cycle after the RD address.
          dma_dout      <= dma_din;
          dma_rd_n      <= 1'b1;
          dma_wr_n      <= 1'b0;
          dma_obj_ena_n <= 1'b0;
          dma_addr      <= {6'b0, obj_addr};
          state         <= S_WR;
        end
        S_WR: begin
          dma_wr_n      <= 1'b1;
          dma_obj_ena_n <= 1'b1;
          if (idx == LAST_IDX) begin
            busrq_n    <= 1'b1;
            dma_active <= 1'b0;
            state      <= S_REL;
          end else begin
            idx      <= idx_nxt;
            dma_rd_n <= 1'b0;
            dma_addr <= {src_q, 8'h00} + {6'b0, idx_nxt};
            state    <= S_RD;
          end
        end
        S_REL: begin
          if (busak_n) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
